// File: rtl/img_pipe_pkg.sv
// Shared encodings for the image pipeline sequencer: operations, error codes,
// controller states and the debug view of the controller.
package img_pipe_pkg;

    typedef enum logic [1:0] {
        OP_BYPASS = 2'd0,
        OP_BRIGHT = 2'd1,
        OP_INVERT = 2'd2,
        OP_THRESH = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        ERR_ABORT   = 2'd0,
        ERR_TIMEOUT = 2'd1,
        ERR_LINE    = 2'd2,
        ERR_FRAME   = 2'd3
    } err_e;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_LAUNCH     = 3'd1,
        S_WAIT_VSYNC = 3'd2,
        S_RUN        = 3'd3,
        S_GAP        = 3'd4,
        S_DONE       = 3'd5,
        S_ERR        = 3'd6
    } seq_state_e;

    typedef struct packed {
        seq_state_e state;
        logic       vsync_seen;
    } seq_dbg_t;

    // Stall timer width is fixed; TIMEOUT must fit in it.
    localparam int TIMER_W = 20;

    // A frame count of zero still runs a single frame.
    function automatic logic [7:0] frames_at_least_one(input logic [7:0] frames);
        return (frames == 8'd0) ? 8'd1 : frames;
    endfunction

endpackage

// File: rtl/img_frame_seq_ctrl_if.sv
// Command channel from the host into the frame sequencer.
// Handshake: a command transfers on a cycle with cmd_valid && cmd_ready; the
// payload must be stable while cmd_valid is high; cmd_ready is high only in IDLE.
interface img_frame_seq_ctrl_if;
    import img_pipe_pkg::*;

    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [7:0] cmd_frames;
    logic [7:0] cmd_value;
    logic [7:0] cmd_thresh;
    logic       cmd_sign;

    modport master (
        output cmd_valid, cmd_op, cmd_frames, cmd_value, cmd_thresh, cmd_sign,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_frames, cmd_value, cmd_thresh, cmd_sign,
        output cmd_ready
    );

endinterface

// File: rtl/img_frame_monitor.sv
// Watches reader HSYNC/done to track pairs per line and lines per frame, and
// times reader inactivity; reports single-cycle status pulses to the FSM.
module img_frame_monitor
    import img_pipe_pkg::*;
#(
    parameter int WIDTH   = 768,
    parameter int HEIGHT  = 512,
    parameter int TIMEOUT = 1048575
) (
    input  logic HCLK,
    input  logic HRESETn,
    input  logic wait_en,
    input  logic run_en,
    input  logic rd_hsync,
    input  logic rd_done,
    output logic start_seen,
    output logic line_ok,
    output logic line_bad,
    output logic frame_ok,
    output logic frame_bad,
    output logic timeout
);

    localparam int PAIRS = WIDTH / 2;
    localparam int PW    = $clog2(PAIRS + 1);
    localparam int LW    = $clog2(HEIGHT + 1);

    localparam logic [PW-1:0]      PAIRS_FULL = PW'(PAIRS);
    localparam logic [PW-1:0]      PAIRS_LAST = PW'(PAIRS - 1);
    localparam logic [LW-1:0]      LINE_LAST  = LW'(HEIGHT - 1);
    localparam logic [TIMER_W-1:0] TIMEOUT_L  = TIMER_W'(TIMEOUT);

    logic [PW-1:0]      pair_cnt;
    logic [LW-1:0]      line_cnt;
    logic [TIMER_W-1:0] timer;
    logic               hsync_d;
    logic               line_end;
    logic               frame_end;
    logic               geom_ok;

    always_comb begin
        line_end   = run_en & hsync_d & ~rd_hsync;
        frame_end  = run_en & rd_done & rd_hsync;
        // pair_cnt is still the pre-increment value on the final data cycle
        geom_ok    = (line_cnt == LINE_LAST) && (pair_cnt == PAIRS_LAST);
        start_seen = wait_en & rd_hsync;
        line_ok    = line_end & (pair_cnt == PAIRS_FULL);
        line_bad   = line_end & (pair_cnt != PAIRS_FULL);
        frame_ok   = frame_end & geom_ok;
        frame_bad  = frame_end & ~geom_ok;
        timeout    = (wait_en | run_en) & (timer == TIMEOUT_L);
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            hsync_d  <= 1'b0;
            pair_cnt <= '0;
            line_cnt <= '0;
            timer    <= '0;
        end else begin
            hsync_d <= rd_hsync;
            if (!(wait_en || run_en)) begin
                pair_cnt <= '0;
                line_cnt <= '0;
                timer    <= '0;
            end else begin
                if (rd_hsync) begin
                    timer <= '0;
                end else if (timer != '1) begin
                    timer <= timer + TIMER_W'(1);
                end

                // Counters saturate so an over-long line or frame is still
                // caught by the full-width compares above.
                if (start_seen) begin
                    pair_cnt <= PW'(1);
                    line_cnt <= '0;
                end else if (run_en) begin
                    if (rd_hsync) begin
                        if (pair_cnt != '1) begin
                            pair_cnt <= pair_cnt + PW'(1);
                        end
                    end else if (line_ok) begin
                        pair_cnt <= '0;
                        if (line_cnt != '1) begin
                            line_cnt <= line_cnt + LW'(1);
                        end
                    end
                end
            end
        end
    end

endmodule

// File: rtl/img_frame_seq_ctrl.sv
// Frame sequencer: accepts one command, holds the pipeline configuration,
// launches the reader once per frame and reports completion or errors.
module img_frame_seq_ctrl
    import img_pipe_pkg::*;
#(
    parameter int WIDTH      = 768,
    parameter int HEIGHT     = 512,
    parameter int GAP_CYCLES = 16,
    parameter int TIMEOUT    = 1048575
) (
    input  logic                       HCLK,
    input  logic                       HRESETn,
    img_frame_seq_ctrl_if.slave        cmd,
    input  logic                       abort,
    output logic                       rd_start,
    input  logic                       rd_vsync,
    input  logic                       rd_hsync,
    input  logic                       rd_done,
    output logic [1:0]                 op_sel,
    output logic [7:0]                 cfg_value,
    output logic [7:0]                 cfg_thresh,
    output logic                       cfg_sign,
    output logic                       busy,
    output logic [7:0]                 frame_idx,
    output logic                       seq_done,
    output logic                       err,
    output logic [1:0]                 err_code,
    output seq_dbg_t                   dbg
);

    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

    seq_state_e state;
    seq_state_e state_next;
    err_e       code_next;

    logic [7:0]    frames_left;
    logic [GW-1:0] gap_cnt;
    logic          vsync_seen;
    logic          accept;
    logic          wait_en;
    logic          run_en;
    logic          start_seen;
    logic          line_ok;
    logic          line_bad;
    logic          frame_ok;
    logic          frame_bad;
    logic          timeout;

    assign wait_en = (state == S_WAIT_VSYNC);
    assign run_en  = (state == S_RUN);
    assign accept  = (state == S_IDLE) && cmd.cmd_valid;

    img_frame_monitor #(
        .WIDTH   (WIDTH),
        .HEIGHT  (HEIGHT),
        .TIMEOUT (TIMEOUT)
    ) u_monitor (
        .HCLK       (HCLK),
        .HRESETn    (HRESETn),
        .wait_en    (wait_en),
        .run_en     (run_en),
        .rd_hsync   (rd_hsync),
        .rd_done    (rd_done),
        .start_seen (start_seen),
        .line_ok    (line_ok),
        .line_bad   (line_bad),
        .frame_ok   (frame_ok),
        .frame_bad  (frame_bad),
        .timeout    (timeout)
    );

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Branch order encodes priority: abort > timeout > frame end > line length.
    always_comb begin
        state_next = state;
        code_next  = ERR_ABORT;
        case (state)
            S_IDLE: begin
                if (accept) state_next = S_LAUNCH;
            end
            S_LAUNCH: begin
                state_next = S_WAIT_VSYNC;
            end
            S_WAIT_VSYNC: begin
                if (timeout) begin
                    state_next = S_ERR;
                    code_next  = ERR_TIMEOUT;
                end else if (start_seen) begin
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (timeout) begin
                    state_next = S_ERR;
                    code_next  = ERR_TIMEOUT;
                end else if (frame_ok) begin
                    state_next = (frames_left == 8'd1) ? S_DONE : S_GAP;
                end else if (frame_bad) begin
                    state_next = S_ERR;
                    code_next  = ERR_FRAME;
                end else if (line_bad) begin
                    state_next = S_ERR;
                    code_next  = ERR_LINE;
                end
            end
            S_GAP: begin
                if (gap_cnt == GAP_LAST) state_next = S_LAUNCH;
            end
            S_DONE:  state_next = S_IDLE;
            S_ERR:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
        if (abort && (state != S_IDLE)) begin
            state_next = S_ERR;
            code_next  = ERR_ABORT;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            op_sel      <= 2'd0;
            cfg_value   <= 8'd0;
            cfg_thresh  <= 8'd0;
            cfg_sign    <= 1'b0;
            frames_left <= 8'd0;
            frame_idx   <= 8'd0;
            err         <= 1'b0;
            err_code    <= 2'd0;
            gap_cnt     <= '0;
            vsync_seen  <= 1'b0;
        end else begin
            if (accept) begin
                op_sel      <= cmd.cmd_op;
                cfg_value   <= cmd.cmd_value;
                cfg_thresh  <= cmd.cmd_thresh;
                cfg_sign    <= cmd.cmd_sign;
                frames_left <= frames_at_least_one(cmd.cmd_frames);
                frame_idx   <= 8'd0;
                err         <= 1'b0;
                err_code    <= 2'd0;
            end

            if (state_next == S_ERR) begin
                err      <= 1'b1;
                err_code <= code_next;
            end

            if (run_en && frame_ok && (state_next != S_ERR)) begin
                frames_left <= frames_left - 8'd1;
                if (state_next == S_GAP) begin
                    frame_idx <= frame_idx + 8'd1;
                end
            end

            gap_cnt <= (state == S_GAP) ? gap_cnt + GW'(1) : '0;

            // VSYNC only feeds the debug view; it does not steer the sequence.
            if (state == S_LAUNCH) begin
                vsync_seen <= 1'b0;
            end else if ((wait_en || run_en) && rd_vsync) begin
                vsync_seen <= 1'b1;
            end
        end
    end

    always_comb begin
        rd_start      = (state == S_LAUNCH);
        busy          = (state != S_IDLE);
        seq_done      = (state == S_DONE);
        cmd.cmd_ready = (state == S_IDLE) && HRESETn;
        dbg.state      = state;
        dbg.vsync_seen = vsync_seen;
    end

endmodule
